// File: rtl/ddr_arb_pkg.sv
// ddr_arb_pkg: shared types, command encodings and the round-robin picker for ddr_cmd_arbiter
package ddr_arb_pkg;
    localparam int MAX_REQ    = 8;
    localparam int DEF_CMD_W  = 32;
    localparam int DEF_DATA_W = 64;
    localparam int DEF_RW_BIT = 31;
    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;
    typedef logic [$clog2(MAX_REQ)-1:0] req_id_t;
    typedef struct packed {
        logic    found;
        req_id_t idx;
    } pick_t;
    // First set bit of mask at or after ptr, wrapping within n requesters
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] mask, input req_id_t ptr, input int n);
        pick_t r;
        int    j;
        r = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= n) j = j - n;
            if (k < n && !r.found && mask[j[2:0]]) begin
                r.found = 1'b1;
                r.idx   = req_id_t'(j);
            end
        end
        return r;
    endfunction
endpackage

// File: rtl/ddr_arb_tag_fifo.sv
// ddr_arb_tag_fifo: in-order FIFO of requester ids for outstanding reads
module ddr_arb_tag_fifo
    import ddr_arb_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  req_id_t       i_din,
    input  logic          i_pop,
    output req_id_t       o_dout,
    output logic          o_full,
    output logic          o_empty,
    output logic [AW:0]   o_count
);
    req_id_t       r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = r_count == (AW+1)'(DEPTH);
    assign o_empty = r_count == '0;
    assign o_count = r_count;
    assign o_dout  = r_mem[r_rd];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    // Tag storage needs no reset; validity is tracked by the pointers
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_din;
    end

    // Pointers and occupancy; a simultaneous push and pop leaves the count unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            r_wr    <= r_wr + AW'(w_push);
            r_rd    <= r_rd + AW'(w_pop);
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
endmodule

// File: rtl/ddr_cmd_arbiter.sv
// ddr_cmd_arbiter: round-robin sharing of the DDR3 user command port; optional starvation guard via DDR_ARB_STARVE_EN
module ddr_cmd_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int CMD_W     = DEF_CMD_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int RW_BIT    = DEF_RW_BIT,
    parameter int BA_LSB    = 0,
`ifdef DDR_ARB_STARVE_EN
    parameter int STARVE_LIMIT = 16,
`endif
    parameter int TAG_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          power_on_rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*CMD_W-1:0]      req_cmd,
    input  logic [NUM_REQ*DATA_W-1:0]     req_wdata,
    input  logic [3:0]                    ba_cmd_pm,
    output logic [CMD_W-1:0]              command,
    output logic                          valid,
    output logic [DATA_W-1:0]             write_data,
    input  logic [DATA_W-1:0]             read_data,
    input  logic                          read_data_valid,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_W-1:0]             rsp_data,
    output logic [$clog2(TAG_DEPTH):0]    outstanding,
    output logic                          err_orphan
);
    logic [1:0]         w_bank [NUM_REQ];
    logic [NUM_REQ-1:0] w_is_rd;
    logic [NUM_REQ-1:0] w_elig;
    logic [NUM_REQ-1:0] w_cand;
    logic [NUM_REQ-1:0] w_head_oh;
    logic [MAX_REQ-1:0] w_mask;
    pick_t              w_pick;
    req_id_t            r_ptr;
    req_id_t            w_head;
    logic [CMD_W-1:0]   w_win_cmd;
    logic [DATA_W-1:0]  w_win_wdata;
    logic               w_win_rd;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_elig
        assign w_bank[g]  = req_cmd[g*CMD_W+BA_LSB +: 2];
        assign w_is_rd[g] = req_cmd[g*CMD_W+RW_BIT] == READ;
        assign w_elig[g]  = req_valid[g] & ba_cmd_pm[w_bank[g]] & (~w_is_rd[g] | ~w_full);
    end

`ifdef DDR_ARB_STARVE_EN
    localparam int WW = $clog2(STARVE_LIMIT+1);
    logic [WW-1:0] r_wait [NUM_REQ];
    logic          w_starve_hit;

    // Saturating per-requester wait counters, cleared on grant or idle
    always_ff @(posedge clk or negedge power_on_rst_n) begin
        if (!power_on_rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) r_wait[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++)
                r_wait[i] <= (!req_valid[i] || req_ready[i]) ? '0 :
                             (r_wait[i] == WW'(STARVE_LIMIT)) ? r_wait[i] : r_wait[i] + 1'b1;
        end
    end

    // Narrow the candidate set to the lowest-index starving requester
    always_comb begin
        w_cand       = w_elig;
        w_starve_hit = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_starve_hit && r_wait[i] >= WW'(STARVE_LIMIT)) begin
                w_starve_hit = 1'b1;
                w_cand       = w_elig & (NUM_REQ'(1) << i);
            end
        end
    end
`else
    assign w_cand = w_elig;
`endif

    assign w_pick      = rr_pick(w_mask, r_ptr, NUM_REQ);
    assign w_win_cmd   = req_cmd[int'(w_pick.idx)*CMD_W +: CMD_W];
    assign w_win_wdata = req_wdata[int'(w_pick.idx)*DATA_W +: DATA_W];
    assign w_win_rd    = w_win_cmd[RW_BIT] == READ;
    assign w_pop       = read_data_valid & ~w_empty;

    // Widen the candidate mask for the picker and decode grant/response one-hots
    always_comb begin
        w_mask    = '0;
        req_ready = '0;
        w_head_oh = '0;
        w_mask[NUM_REQ-1:0] = w_cand;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = w_pick.found && w_pick.idx == req_id_t'(i);
            w_head_oh[i] = w_head == req_id_t'(i);
        end
    end

    ddr_arb_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tags (
        .clk     (clk),
        .rst_n   (power_on_rst_n),
        .i_push  (w_pick.found & w_win_rd),
        .i_din   (w_pick.idx),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (outstanding)
    );

    // Issue the granted command, advance the RR pointer and route read returns
    always_ff @(posedge clk or negedge power_on_rst_n) begin
        if (!power_on_rst_n) begin
            r_ptr      <= '0;
            command    <= '0;
            valid      <= 1'b0;
            write_data <= '0;
            rsp_valid  <= '0;
            rsp_data   <= '0;
            err_orphan <= 1'b0;
        end else begin
            if (w_pick.found) begin
                r_ptr      <= (w_pick.idx == req_id_t'(NUM_REQ-1)) ? '0 : w_pick.idx + req_id_t'(1);
                write_data <= (w_win_cmd[RW_BIT] == WRITE) ? w_win_wdata : '0;
            end
            command    <= w_pick.found ? w_win_cmd : '0;
            valid      <= w_pick.found;
            rsp_valid  <= w_pop ? w_head_oh : '0;
            if (w_pop) rsp_data <= read_data;
            err_orphan <= err_orphan | (read_data_valid & w_empty);
        end
    end
endmodule

// File: tb/tb_ddr_cmd_arbiter.sv
// tb_ddr_cmd_arbiter: directed checks of arbitration, bank backpressure, read routing, tag-FIFO full and orphan returns
module tb_ddr_cmd_arbiter;
    localparam int NR = 4;
    localparam int CW = 32;
    localparam int DW = 64;

    logic            clk = 1'b0;
    logic            power_on_rst_n = 1'b0;
    logic [NR-1:0]   req_valid = '0;
    logic [NR-1:0]   req_ready;
    logic [NR*CW-1:0] req_cmd = '0;
    logic [NR*DW-1:0] req_wdata = '0;
    logic [3:0]      ba_cmd_pm = '0;
    logic [CW-1:0]   command;
    logic            valid;
    logic [DW-1:0]   write_data;
    logic [DW-1:0]   read_data = '0;
    logic            read_data_valid = 1'b0;
    logic [NR-1:0]   rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic [3:0]      outstanding;
    logic            err_orphan;
    int total = 0;
    int bad = 0;

    ddr_cmd_arbiter #(.NUM_REQ(NR), .CMD_W(CW), .DATA_W(DW), .RW_BIT(31), .BA_LSB(0), .TAG_DEPTH(8)) dut (
        .clk(clk), .power_on_rst_n(power_on_rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_cmd(req_cmd), .req_wdata(req_wdata), .ba_cmd_pm(ba_cmd_pm), .command(command),
        .valid(valid), .write_data(write_data), .read_data(read_data), .read_data_valid(read_data_valid),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .outstanding(outstanding), .err_orphan(err_orphan)
    );

    always #5 clk = ~clk;

    function automatic logic [CW-1:0] mk(input logic rd, input logic [1:0] ba, input logic [5:0] tag);
        return {rd, 23'd0, tag, ba};
    endfunction

    task automatic put(input int i, input logic [CW-1:0] c, input logic [DW-1:0] d);
        req_cmd[i*CW +: CW]   = c;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        power_on_rst_n = 1'b0;
        ba_cmd_pm = '0;
        for (int k = 0; k < 3; k++) begin
            req_valid = NR'($urandom);
            for (int i = 0; i < NR; i++) put(i, $urandom, {$urandom, $urandom});
            read_data = {$urandom, $urandom};
            read_data_valid = 1'($urandom);
            step();
        end
        total++; if (command !== '0) begin bad++; $display("FAIL reset_command got=%h exp=0", command); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid); end
        total++; if (write_data !== '0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", write_data); end
        total++; if (rsp_valid !== '0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        total++; if (rsp_data !== '0) begin bad++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
        total++; if (outstanding !== '0) begin bad++; $display("FAIL reset_outstanding got=%0d exp=0", outstanding); end
        total++; if (err_orphan !== 1'b0) begin bad++; $display("FAIL reset_err_orphan got=%b exp=0", err_orphan); end
        total++; if (req_ready !== '0) begin bad++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
        req_valid = '0;
        req_cmd = '0;
        req_wdata = '0;
        read_data = '0;
        read_data_valid = 1'b0;
        step();
        power_on_rst_n = 1'b1;
        step();
    endtask

    task automatic test_fairness;
        int w;
        ba_cmd_pm = 4'hF;
        for (int i = 0; i < NR; i++) put(i, mk(1'b0, 2'd0, 6'(i)), 64'h1000 + 64'(i));
        req_valid = '1;
        for (int k = 0; k < 6; k++) begin
            w = k % NR;
            #1;
            total++; if (req_ready !== NR'(1 << w)) begin bad++; $display("FAIL fair_ready[%0d] got=%b exp=%b", k, req_ready, NR'(1 << w)); end
            step();
            total++; if (valid !== 1'b1) begin bad++; $display("FAIL fair_valid[%0d] got=%b exp=1", k, valid); end
            total++; if (command !== mk(1'b0, 2'd0, 6'(w))) begin bad++; $display("FAIL fair_cmd[%0d] got=%h exp=%h", k, command, mk(1'b0, 2'd0, 6'(w))); end
            total++; if (write_data !== 64'h1000 + 64'(w)) begin bad++; $display("FAIL fair_wdata[%0d] got=%h exp=%h", k, write_data, 64'h1000 + 64'(w)); end
        end
        req_valid = '0;
        step();
        total++; if (valid !== 1'b0 || command !== '0) begin bad++; $display("FAIL idle_after_fair got=%b/%h exp=0/0", valid, command); end
    endtask

    task automatic test_bank_backpressure;
        ba_cmd_pm = 4'b1110;
        put(0, mk(1'b0, 2'd0, 6'h10), 64'hA0A0);
        put(1, mk(1'b0, 2'd1, 6'h11), 64'hB1B1);
        req_valid = 4'b0011;
        #1;
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL bank_ready1 got=%b exp=0010", req_ready); end
        step();
        total++; if (command !== mk(1'b0, 2'd1, 6'h11) || valid !== 1'b1) begin bad++; $display("FAIL bank_cmd1 got=%h exp=%h", command, mk(1'b0, 2'd1, 6'h11)); end
        req_valid = 4'b0001;
        #1;
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL bank_ready_wait got=%b exp=0000", req_ready); end
        step();
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL bank_valid_wait got=%b exp=0", valid); end
        ba_cmd_pm = 4'b1111;
        #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL bank_ready0 got=%b exp=0001", req_ready); end
        step();
        total++; if (command !== mk(1'b0, 2'd0, 6'h10) || write_data !== 64'hA0A0) begin bad++; $display("FAIL bank_cmd0 got=%h/%h exp=%h/a0a0", command, write_data, mk(1'b0, 2'd0, 6'h10)); end
        req_valid = '0;
        step();
    endtask

    task automatic test_read_routing;
        int order [3] = '{2, 0, 3};
        logic [3:0] exp_rsp [3] = '{4'b0100, 4'b0001, 4'b1000};
        logic [DW-1:0] rd [3] = '{64'hA, 64'hB, 64'hC};
        ba_cmd_pm = 4'hF;
        for (int i = 0; i < NR; i++) put(i, mk(1'b1, 2'(i), 6'h20 + 6'(i)), 64'hDEAD);
        for (int k = 0; k < 3; k++) begin
            req_valid = NR'(1 << order[k]);
            #1;
            total++; if (req_ready !== NR'(1 << order[k])) begin bad++; $display("FAIL rd_ready[%0d] got=%b exp=%b", k, req_ready, NR'(1 << order[k])); end
            step();
            total++; if (write_data !== '0 || outstanding !== 4'(k + 1)) begin bad++; $display("FAIL rd_issue[%0d] got=%h/%0d exp=0/%0d", k, write_data, outstanding, k + 1); end
        end
        req_valid = '0;
        step();
        for (int k = 0; k < 3; k++) begin
            read_data = rd[k];
            read_data_valid = 1'b1;
            step();
            total++; if (rsp_valid !== exp_rsp[k] || rsp_data !== rd[k]) begin bad++; $display("FAIL rd_rsp[%0d] got=%b/%h exp=%b/%h", k, rsp_valid, rsp_data, exp_rsp[k], rd[k]); end
            total++; if (outstanding !== 4'(2 - k)) begin bad++; $display("FAIL rd_outstanding[%0d] got=%0d exp=%0d", k, outstanding, 2 - k); end
        end
        read_data_valid = 1'b0;
        step();
        total++; if (rsp_valid !== '0) begin bad++; $display("FAIL rd_rsp_idle got=%b exp=0", rsp_valid); end
    endtask

    task automatic test_fifo_full;
        ba_cmd_pm = 4'hF;
        put(1, mk(1'b1, 2'd1, 6'h31), 64'h0);
        put(2, mk(1'b0, 2'd2, 6'h32), 64'h2222);
        req_valid = 4'b0010;
        for (int k = 0; k < 8; k++) begin
            #1;
            total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL full_fill_ready[%0d] got=%b exp=0010", k, req_ready); end
            step();
        end
        total++; if (outstanding !== 4'd8) begin bad++; $display("FAIL full_count got=%0d exp=8", outstanding); end
        req_valid = 4'b0110;
        #1;
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL full_write_ready got=%b exp=0100", req_ready); end
        step();
        total++; if (command !== mk(1'b0, 2'd2, 6'h32) || write_data !== 64'h2222) begin bad++; $display("FAIL full_write_cmd got=%h/%h exp=%h/2222", command, write_data, mk(1'b0, 2'd2, 6'h32)); end
        req_valid = 4'b0010;
        read_data = 64'h77;
        read_data_valid = 1'b1;
        #1;
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL full_pop_cycle_ready got=%b exp=0000", req_ready); end
        step();
        total++; if (rsp_valid !== 4'b0010 || outstanding !== 4'd7) begin bad++; $display("FAIL full_pop got=%b/%0d exp=0010/7", rsp_valid, outstanding); end
        read_data_valid = 1'b0;
        #1;
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL full_after_pop_ready got=%b exp=0010", req_ready); end
        step();
        total++; if (command !== mk(1'b1, 2'd1, 6'h31) || outstanding !== 4'd8) begin bad++; $display("FAIL full_read_issue got=%h/%0d exp=%h/8", command, outstanding, mk(1'b1, 2'd1, 6'h31)); end
        req_valid = '0;
        read_data_valid = 1'b1;
        for (int k = 0; k < 8; k++) step();
        read_data_valid = 1'b0;
        step();
        total++; if (outstanding !== 4'd0 || err_orphan !== 1'b0) begin bad++; $display("FAIL full_drain got=%0d/%b exp=0/0", outstanding, err_orphan); end
    endtask

    task automatic test_orphan_reset;
        put(0, mk(1'b1, 2'd0, 6'h3F), 64'h0);
        req_valid = 4'b0001;
        step();
        step();
        req_valid = '0;
        #1;
        total++; if (outstanding !== 4'd2) begin bad++; $display("FAIL orphan_pre got=%0d exp=2", outstanding); end
        power_on_rst_n = 1'b0;
        #2;
        total++; if (outstanding !== 4'd0) begin bad++; $display("FAIL orphan_async_clear got=%0d exp=0", outstanding); end
        power_on_rst_n = 1'b1;
        step();
        read_data = 64'h55;
        read_data_valid = 1'b1;
        step();
        total++; if (rsp_valid !== '0 || err_orphan !== 1'b1) begin bad++; $display("FAIL orphan_first got=%b/%b exp=0000/1", rsp_valid, err_orphan); end
        step();
        read_data_valid = 1'b0;
        total++; if (rsp_valid !== '0 || outstanding !== 4'd0) begin bad++; $display("FAIL orphan_second got=%b/%0d exp=0000/0", rsp_valid, outstanding); end
        step();
        total++; if (err_orphan !== 1'b1) begin bad++; $display("FAIL orphan_sticky got=%b exp=1", err_orphan); end
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_bank_backpressure();
        test_read_routing();
        test_fifo_full();
        test_orphan_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
